// File: rtl/decode_issue_if.sv
// Fetch-side, writeback and execute-side signals of the decode/issue stage.
// slave = decode_issue itself; master = the surrounding pipeline (or a bench).
interface decode_issue_if;
    logic [15:0] instruction;
    logic [7:0]  pc_in;
    logic        valid;
    logic        stall;
    logic        flush;
    logic        PC_sel;
    logic [7:0]  branch_target;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic [7:0]  ex_a;
    logic [7:0]  ex_b;
    logic [7:0]  ex_pc;
    logic        halted;

    modport slave (
        input  instruction, pc_in, valid, wb_en, wb_rd, wb_data,
        output stall, flush, PC_sel, branch_target,
        output ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_pc, halted
    );

    modport master (
        output instruction, pc_in, valid, wb_en, wb_rd, wb_data,
        input  stall, flush, PC_sel, branch_target,
        input  ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_pc, halted
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: 16-bit ISA decode, 16x8 register file with writeback
// bypass, busy-bit scoreboard, one-entry hold buffer, branch resolution.
module decode_issue (
    input  logic          clk,
    input  logic          reset,
    decode_issue_if.slave bus
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LOAD = 4'h7,
        OP_BEQZ = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;

    hold_e       hold_state, hold_next;
    logic [15:0] hold_instr;
    logic [7:0]  hold_pc;
    logic [7:0]  rf [16];
    logic [15:0] busy, busy_next;
    logic        halted;

    logic        ex_valid_q;
    logic [3:0]  ex_op_q, ex_rd_q;
    logic [7:0]  ex_a_q, ex_b_q, ex_pc_q;

    logic [15:0] cur_instr;
    logic [7:0]  cur_pc;
    logic        cur_present;
    op_e         op;
    logic [3:0]  rd, rs1, rs2;
    logic [7:0]  rd_val, rs1_val, rs2_val;
    logic        uses_rs1, uses_rs2, uses_rd_src, writes_rd, is_branch;
    logic        hazard, issue, stall, taken;

    function automatic logic [7:0] read_reg(input logic [3:0] r, input logic [7:0] stored,
                                            input logic we, input logic [3:0] wr,
                                            input logic [7:0] wd);
        if (r == 4'd0)
            return '0;
        else if (we && wr == r)
            return wd;
        else
            return stored;
    endfunction

    // A register being written back this cycle is already free for readers.
    function automatic logic is_busy(input logic [3:0] r, input logic busy_bit,
                                     input logic we, input logic [3:0] wr);
        return (r != 4'd0) && busy_bit && !(we && wr == r);
    endfunction

    always_comb begin
        cur_present = !halted && (hold_state == HOLD_FULL || bus.valid);
        cur_instr   = (hold_state == HOLD_FULL) ? hold_instr : bus.instruction;
        cur_pc      = (hold_state == HOLD_FULL) ? hold_pc : bus.pc_in;
        op          = op_e'(cur_instr[15:12]);
        rd          = cur_instr[11:8];
        rs1         = cur_instr[7:4];
        rs2         = cur_instr[3:0];

        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        uses_rd_src = 1'b0;
        writes_rd   = 1'b0;
        is_branch   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_ADDI, OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_BEQZ: begin
                uses_rd_src = 1'b1;
                is_branch   = 1'b1;
            end
            OP_JMP:  is_branch = 1'b1;
            default: ;
        endcase

        rd_val  = read_reg(rd,  rf[rd],  bus.wb_en, bus.wb_rd, bus.wb_data);
        rs1_val = read_reg(rs1, rf[rs1], bus.wb_en, bus.wb_rd, bus.wb_data);
        rs2_val = read_reg(rs2, rf[rs2], bus.wb_en, bus.wb_rd, bus.wb_data);

        hazard = (uses_rs1 && is_busy(rs1, busy[rs1], bus.wb_en, bus.wb_rd))
              || (uses_rs2 && is_busy(rs2, busy[rs2], bus.wb_en, bus.wb_rd))
              || (uses_rd_src && is_busy(rd, busy[rd], bus.wb_en, bus.wb_rd))
              || (writes_rd && is_busy(rd, busy[rd], bus.wb_en, bus.wb_rd));
        issue  = cur_present && !hazard;
        stall  = cur_present && hazard;
        taken  = issue && (op == OP_JMP || (op == OP_BEQZ && rd_val == 8'd0));
    end

    // Set after clear so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (bus.wb_en)
            busy_next[bus.wb_rd] = 1'b0;
        if (issue && writes_rd)
            busy_next[rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        hold_next = hold_state;
        case (hold_state)
            HOLD_EMPTY: if (stall) hold_next = HOLD_FULL;
            HOLD_FULL:  if (issue) hold_next = HOLD_EMPTY;
            default:    hold_next = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_state <= HOLD_EMPTY;
            hold_instr <= '0;
            hold_pc    <= '0;
            busy       <= '0;
            halted     <= 1'b0;
            for (int unsigned i = 0; i < 16; i++)
                rf[i] <= '0;
        end else begin
            hold_state <= hold_next;
            if (hold_state == HOLD_EMPTY && stall) begin
                hold_instr <= bus.instruction;
                hold_pc    <= bus.pc_in;
            end
            busy <= busy_next;
            if (issue && op == OP_HALT)
                halted <= 1'b1;
            if (bus.wb_en && bus.wb_rd != 4'd0)
                rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_pc_q    <= '0;
        end else begin
            ex_valid_q <= issue;
            if (issue) begin
                ex_op_q <= cur_instr[15:12];
                ex_rd_q <= is_branch ? 4'd0 : rd;
                ex_a_q  <= uses_rd_src ? rd_val : rs1_val;
                ex_b_q  <= uses_rs2 ? rs2_val : {4'b0000, cur_instr[3:0]};
                ex_pc_q <= cur_pc;
            end
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = taken;
    assign bus.PC_sel        = taken;
    assign bus.branch_target = taken ? cur_instr[7:0] : '0;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_op         = ex_op_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_a          = ex_a_q;
    assign bus.ex_b          = ex_b_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.halted        = halted;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a per-cycle vector table plus hand-written
// reset-during-stall sequence.
module tb_decode_issue;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    decode_issue_if bus ();

    decode_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
        logic        valid;
        logic        wb_en;
        logic [3:0]  wb_rd;
        logic [7:0]  wb_data;
        logic        stall;
        logic        flush;
        logic [7:0]  tgt;
        logic        ev;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  epc;
        logic        halted;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic [7:0] pc, input logic v,
                         input logic we, input logic [3:0] wr, input logic [7:0] wd);
        bus.instruction = instr;
        bus.pc_in       = pc;
        bus.valid       = v;
        bus.wb_en       = we;
        bus.wb_rd       = wr;
        bus.wb_data     = wd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

        //          instr     pc     v     we    wr    wd      stall fl    tgt    ev    op    rd    a      b      epc    halt
        tbl[0]  = '{16'h6105, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h6, 4'h1, 8'h00, 8'h05, 8'h00, 1'b0};
        tbl[1]  = '{16'h6203, 8'h01, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h6, 4'h2, 8'h00, 8'h03, 8'h01, 1'b0};
        tbl[2]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h2, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{16'h6109, 8'h02, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h6, 4'h1, 8'h00, 8'h09, 8'h02, 1'b0};
        tbl[5]  = '{16'h1312, 8'h03, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h1, 8'h09, 1'b0, 1'b0, 8'h00, 1'b1, 4'h1, 4'h3, 8'h09, 8'h03, 8'h03, 1'b0};
        tbl[9]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h3, 8'h0C, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{16'h9440, 8'h04, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, 4'h9, 4'h0, 8'h00, 8'h00, 8'h04, 1'b0};
        tbl[11] = '{16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[12] = '{16'h6407, 8'h40, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h6, 4'h4, 8'h00, 8'h07, 8'h40, 1'b0};
        tbl[13] = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h4, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[14] = '{16'h9440, 8'h41, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h9, 4'h0, 8'h07, 8'h00, 8'h41, 1'b0};
        tbl[15] = '{16'h6501, 8'h42, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h6, 4'h5, 8'h00, 8'h01, 8'h42, 1'b0};
        tbl[16] = '{16'hA010, 8'h43, 1'b1, 1'b1, 4'h5, 8'h01, 1'b0, 1'b1, 8'h10, 1'b1, 4'hA, 4'h0, 8'h09, 8'h00, 8'h43, 1'b0};
        tbl[17] = '{16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[18] = '{16'h1650, 8'h10, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'h1, 4'h6, 8'h01, 8'h00, 8'h10, 1'b0};
        tbl[19] = '{16'h0000, 8'h00, 1'b0, 1'b1, 4'h6, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[20] = '{16'hF000, 8'h06, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'hF, 4'h0, 8'h00, 8'h00, 8'h06, 1'b1};
        tbl[21] = '{16'h6107, 8'h07, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[22] = '{16'h6107, 8'h08, 1'b1, 1'b1, 4'h1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b1};

        // Reset state
        #2;
        chk("reset stall",    {15'd0, bus.stall},    16'd0);
        chk("reset flush",    {15'd0, bus.flush},    16'd0);
        chk("reset pc_sel",   {15'd0, bus.PC_sel},   16'd0);
        chk("reset target",   {8'd0, bus.branch_target}, 16'd0);
        chk("reset ex_valid", {15'd0, bus.ex_valid}, 16'd0);
        chk("reset ex_a",     {8'd0, bus.ex_a},      16'd0);
        chk("reset halted",   {15'd0, bus.halted},   16'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].instr, tbl[i].pc, tbl[i].valid, tbl[i].wb_en, tbl[i].wb_rd, tbl[i].wb_data);
            #3;
            chk($sformatf("row%0d stall", i),  {15'd0, bus.stall},  {15'd0, tbl[i].stall});
            chk($sformatf("row%0d flush", i),  {15'd0, bus.flush},  {15'd0, tbl[i].flush});
            chk($sformatf("row%0d pc_sel", i), {15'd0, bus.PC_sel}, {15'd0, tbl[i].flush});
            chk($sformatf("row%0d target", i), {8'd0, bus.branch_target}, {8'd0, tbl[i].tgt});
            @(posedge clk); #1;
            chk($sformatf("row%0d ex_valid", i), {15'd0, bus.ex_valid}, {15'd0, tbl[i].ev});
            chk($sformatf("row%0d halted", i),   {15'd0, bus.halted},   {15'd0, tbl[i].halted});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d ex_op", i), {12'd0, bus.ex_op}, {12'd0, tbl[i].op});
                chk($sformatf("row%0d ex_rd", i), {12'd0, bus.ex_rd}, {12'd0, tbl[i].rd});
                chk($sformatf("row%0d ex_a", i),  {8'd0, bus.ex_a},   {8'd0, tbl[i].a});
                chk($sformatf("row%0d ex_b", i),  {8'd0, bus.ex_b},   {8'd0, tbl[i].b});
                chk($sformatf("row%0d ex_pc", i), {8'd0, bus.ex_pc},  {8'd0, tbl[i].epc});
            end
        end

        // Reset while ADD r3,r1,r2 is stalled on r1 (also clears halted)
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        drive(16'h6102, 8'h20, 1'b1, 1'b0, 4'h0, 8'h00);
        @(posedge clk); #1;
        drive(16'h1312, 8'h21, 1'b1, 1'b0, 4'h0, 8'h00);
        #3;
        chk("rst pre stall", {15'd0, bus.stall}, 16'd1);
        @(posedge clk); #1;
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        chk("rst held stall", {15'd0, bus.stall}, 16'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst stall",    {15'd0, bus.stall},    16'd0);
        chk("rst ex_valid", {15'd0, bus.ex_valid}, 16'd0);
        chk("rst ex_op",    {12'd0, bus.ex_op},    16'd0);
        chk("rst ex_rd",    {12'd0, bus.ex_rd},    16'd0);
        chk("rst ex_b",     {8'd0, bus.ex_b},      16'd0);
        chk("rst ex_pc",    {8'd0, bus.ex_pc},     16'd0);
        chk("rst pc_sel",   {15'd0, bus.PC_sel},   16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(16'h1312, 8'h22, 1'b1, 1'b0, 4'h0, 8'h00);
        #3;
        chk("post rst stall", {15'd0, bus.stall}, 16'd0);
        @(posedge clk); #1;
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("post rst ex_valid", {15'd0, bus.ex_valid}, 16'd1);
        chk("post rst ex_op",    {12'd0, bus.ex_op},    16'd1);
        chk("post rst ex_rd",    {12'd0, bus.ex_rd},    16'd3);
        chk("post rst ex_a",     {8'd0, bus.ex_a},      16'd0);
        chk("post rst ex_pc",    {8'd0, bus.ex_pc},     16'h22);
        @(posedge clk); #1;
        chk("post rst idle", {15'd0, bus.ex_valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
